// File: rtl/reg_file_pkg.sv
// Shared types, default widths and the bank-advance helper for the banked register file.
package reg_file_pkg;

  typedef enum logic {RF_CLEAR, RF_IDLE} rf_state_t;

  localparam int unsigned RF_DATA_W    = 8;
  localparam int unsigned RF_ADDR_W    = 5;
  localparam int unsigned RF_NUM_BANKS = 2;

  function automatic int unsigned rf_next_bank(input int unsigned bank,
                                               input int unsigned num_banks);
    return (bank == num_banks - 1) ? 0 : bank + 1;
  endfunction

endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks every entry index once after reset or CLR_REQ, then reports READY.
module rf_clear_seq
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr_req,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_ready
);

  rf_state_t         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RF_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      RF_CLEAR: begin
        // Leave CLEAR after the last index instead of wrapping the counter.
        if (i_clr_req) begin
          w_cnt_nxt = '0;
        end else if (&r_cnt) begin
          w_state_nxt = RF_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      RF_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = RF_CLEAR;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = RF_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_clr_we   = (r_state == RF_CLEAR);
  assign o_clr_addr = r_cnt;
  assign o_ready    = (r_state == RF_IDLE);

endmodule

// File: rtl/reg_file_banked.sv
// Multi-bank register file, 1 write / 2 async read ports, with swap pulse and clear sequencer.
// Optional WRITE_BYPASS_EN makes same-cycle reads return the write data (write-first).
module reg_file_banked
  import reg_file_pkg::*;
#(
  parameter  int unsigned DATA_W    = RF_DATA_W,
  parameter  int unsigned ADDR_W    = RF_ADDR_W,
  parameter  int unsigned NUM_BANKS = RF_NUM_BANKS,
  localparam int unsigned BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] i_din,
  input  logic [ADDR_W-1:0] i_adrx,
  input  logic [ADDR_W-1:0] i_adry,
  input  logic              i_rf_wr,
  input  logic              i_bank_swp,
  input  logic              i_clr_req,
  output logic [DATA_W-1:0] o_dx_out,
  output logic [DATA_W-1:0] o_dy_out,
  output logic [BANK_W-1:0] o_bank,
  output logic              o_ready
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [NUM_BANKS][DEPTH];
  logic [BANK_W-1:0] r_bank;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_ready;
  logic              w_user_wr;
  logic              w_user_swp;
  logic [DATA_W-1:0] w_dx_raw;
  logic [DATA_W-1:0] w_dy_raw;

  rf_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_clr_req (i_clr_req),
    .o_clr_we  (w_clr_we),
    .o_clr_addr(w_clr_addr),
    .o_ready   (w_ready)
  );

  // A clear request in IDLE swallows any same-cycle write or swap.
  assign w_user_wr  = w_ready & i_rf_wr & ~i_clr_req;
  assign w_user_swp = w_ready & i_bank_swp & ~i_clr_req;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bank <= '0;
    end else if (w_user_swp) begin
      r_bank <= BANK_W'(rf_next_bank(32'(r_bank), NUM_BANKS));
    end
  end

  // Array contents have no reset; the clear sequencer zeroes them instead.
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_mem[b][w_clr_addr] <= '0;
      end
    end else if (w_user_wr) begin
      r_mem[r_bank][i_adrx] <= i_din;
    end
  end

  always_comb begin
    w_dx_raw = r_mem[r_bank][i_adrx];
    w_dy_raw = r_mem[r_bank][i_adry];
`ifdef WRITE_BYPASS_EN
    if (w_ready && i_rf_wr) begin
      w_dx_raw = i_din;
      if (i_adry == i_adrx) begin
        w_dy_raw = i_din;
      end
    end
`endif
  end

  assign o_dx_out = w_ready ? w_dx_raw : '0;
  assign o_dy_out = w_ready ? w_dy_raw : '0;
  assign o_bank   = r_bank;
  assign o_ready  = w_ready;

endmodule
